// File: rtl/main_memory_responder.sv
// Multi-cycle backing memory for the cache controller: 4-word block reads after a fixed
// latency, single-word write-through commits, one-cycle Mem_Done pulse per transaction.
module main_memory_responder #(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Memory_Read_En,
    input  logic         Memory_Write_En,
    input  logic [31:0]  Address,
    input  logic [31:0]  Write_Data,
    output logic [127:0] Block_Data,
    output logic         Mem_Done,
    output logic         Mem_Busy
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {StIdle, StWait, StBurst, StWcommit, StDone} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     beat_q, beat_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           is_write_q, is_write_d;
    logic [31:0]    beat_buf_q [4];
    logic [31:0]    beat_buf_d [4];
    logic [127:0]   block_q, block_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           mem_we;
    logic [31:0]    rd_word;
    logic [31:0]    mem_q [DEPTH_WORDS];

    // Address bits outside the word index are deliberately dropped (natural aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Address[31:AW+2], Address[1:0]};

    // Block reads ignore the captured word offset and walk the aligned 4-word group.
    assign rd_word = mem_q[{addr_q[AW-1:2], beat_q}];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        beat_buf_d = beat_buf_q;
        block_d    = block_q;
        mem_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Memory_Write_En || Memory_Read_En) begin
                    addr_d     = Address[AW+1:2];
                    wdata_d    = Write_Data;
                    is_write_d = Memory_Write_En;
                    cnt_d      = 4'(LATENCY);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    beat_d  = 2'd0;
                    state_d = is_write_q ? StWcommit : StBurst;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StBurst: begin
                beat_buf_d[beat_q] = rd_word;
                beat_d             = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    block_d = {beat_buf_d[3], beat_buf_d[2], beat_buf_d[1], beat_buf_d[0]};
                    state_d = StDone;
                end
            end
            StWcommit: begin
                mem_we  = ~rst;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        done_d = (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            beat_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            block_q    <= 128'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            block_q    <= block_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Beat buffer and array contents survive reset.
    always_ff @(posedge clk) begin
        beat_buf_q <= beat_buf_d;
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign Block_Data = block_q;
    assign Mem_Done   = done_q;
    assign Mem_Busy   = busy_q;
endmodule
